// File: rtl/key_event_decoder_pkg.sv
// Shared definitions for the key event decoder: FSM state codes, event bundle,
// millisecond counter width and default timing constants.
package key_event_decoder_pkg;

   localparam int MS_CNT_W         = 16;
   localparam int DEF_TICK_DIV     = 50000;
   localparam int DEF_LONG_MS      = 1000;
   localparam int DEF_REPEAT_MS    = 200;
   localparam int DEF_DCLICK_MS    = 300;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_PRESS    = 3'd1;
   localparam logic [2:0] ST_HOLD     = 3'd2;
   localparam logic [2:0] ST_GAP      = 3'd3;
   localparam logic [2:0] ST_WAIT_REL = 3'd4;

   typedef struct packed {
      logic short_p;
      logic long_p;
      logic repeat_p;
      logic double_p;
   } key_evt_t;

   function automatic logic is_held_state(input logic [2:0] st);
      return (st == ST_PRESS) || (st == ST_HOLD) || (st == ST_WAIT_REL);
   endfunction

endpackage

// File: rtl/key_event_decoder_if.sv
// Key-event bundle: debounced edge pulse and level in, one-cycle user events
// and the held level out.
interface key_event_decoder_if;
   logic key_flag;
   logic key_state;
   logic evt_short;
   logic evt_long;
   logic evt_repeat;
   logic evt_double;
   logic key_held;

   modport master (
      output key_flag, key_state,
      input  evt_short, evt_long, evt_repeat, evt_double, key_held
   );

   modport slave (
      input  key_flag, key_state,
      output evt_short, evt_long, evt_repeat, evt_double, key_held
   );
endinterface

// File: rtl/key_ms_tick.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 and asserts tick while holding
// the last count; a synchronous clear restarts the period.
module key_ms_tick
   import key_event_decoder_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg + 1'b1;
      if (clr || (cnt_reg == CNT_LAST)) begin
         cnt_next = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/key_event_decoder.sv
// Turns debounced key edges into short / long / repeat / double-click pulses.
// Define KEY_EVT_DOUBLE_EN to compile in the double-click gap detection.
module key_event_decoder
   import key_event_decoder_pkg::*;
#(
   parameter int TICK_DIV  = DEF_TICK_DIV,
   parameter int LONG_MS   = DEF_LONG_MS,
   parameter int REPEAT_MS = DEF_REPEAT_MS,
   parameter int DCLICK_MS = DEF_DCLICK_MS
) (
   input  logic                clk,
   input  logic                rst_n,
   key_event_decoder_if.slave  bus
);

   // A threshold is met on the tick that brings ms_cnt up to the limit.
   localparam logic [MS_CNT_W-1:0] LONG_LAST   = MS_CNT_W'(LONG_MS - 1);
   localparam logic [MS_CNT_W-1:0] REPEAT_LAST = MS_CNT_W'(REPEAT_MS - 1);
   localparam logic [MS_CNT_W-1:0] GAP_LAST    = MS_CNT_W'(DCLICK_MS - 1);

   logic                press_edge;
   logic                rel_edge;
   logic                tick;
   logic                state_chg;
   logic                ms_clr;
   logic [2:0]          state_reg;
   logic [2:0]          state_next;
   logic [MS_CNT_W-1:0] ms_cnt_reg;
   logic [MS_CNT_W-1:0] ms_cnt_next;
   key_evt_t            evt_reg;
   key_evt_t            evt_next;
   logic                held_reg;

   assign press_edge = bus.key_flag & ~bus.key_state;
   assign rel_edge   = bus.key_flag &  bus.key_state;

   key_ms_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_ms_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_chg),
      .tick  (tick)
   );

   // Edges are tested before ticks so a same-cycle edge wins over a threshold.
   always_comb begin
      state_next = state_reg;
      evt_next   = '0;
      ms_clr     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (press_edge) begin
               state_next = ST_PRESS;
            end
         end
         ST_PRESS: begin
            if (rel_edge) begin
`ifdef KEY_EVT_DOUBLE_EN
               state_next = ST_GAP;
`else
               state_next       = ST_IDLE;
               evt_next.short_p = 1'b1;
`endif
            end else if (tick && (ms_cnt_reg == LONG_LAST)) begin
               state_next      = ST_HOLD;
               evt_next.long_p = 1'b1;
            end
         end
         ST_HOLD: begin
            if (rel_edge) begin
               state_next = ST_IDLE;
            end else if (tick && (ms_cnt_reg == REPEAT_LAST)) begin
               evt_next.repeat_p = 1'b1;
               ms_clr            = 1'b1;
            end
         end
`ifdef KEY_EVT_DOUBLE_EN
         ST_GAP: begin
            if (press_edge) begin
               state_next        = ST_WAIT_REL;
               evt_next.double_p = 1'b1;
            end else if (tick && (ms_cnt_reg == GAP_LAST)) begin
               state_next       = ST_IDLE;
               evt_next.short_p = 1'b1;
            end
         end
         ST_WAIT_REL: begin
            if (rel_edge) begin
               state_next = ST_IDLE;
            end
         end
`endif
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign state_chg = (state_next != state_reg);

   always_comb begin
      ms_cnt_next = ms_cnt_reg;
      if (state_chg || ms_clr) begin
         ms_cnt_next = '0;
      end else if (tick && (ms_cnt_reg != {MS_CNT_W{1'b1}})) begin
         ms_cnt_next = ms_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ST_IDLE;
         ms_cnt_reg <= '0;
         evt_reg    <= '0;
         held_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         ms_cnt_reg <= ms_cnt_next;
         evt_reg    <= evt_next;
         held_reg   <= is_held_state(state_next);
      end
   end

   assign bus.evt_short  = evt_reg.short_p;
   assign bus.evt_long   = evt_reg.long_p;
   assign bus.evt_repeat = evt_reg.repeat_p;
   assign bus.evt_double = evt_reg.double_p;
   assign bus.key_held   = held_reg;

endmodule
